// File: rtl/yuv_to_rgb_converter.sv
// Frame colour-space stage: reads 4:2:2 YUV groups from SRAM, converts four pixels
// per group to 8-bit RGB and writes six packed RGB words back.
module yuv_to_rgb_converter #(
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter logic [14:0] NUM_GROUPS = 15'd19200,
  parameter int          RD_LAT     = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);
  localparam logic [4:0] S_IDLE  = 5'd0,  S_RD0   = 5'd1,  S_RD1   = 5'd2,  S_RD2   = 5'd3,
                         S_RD3   = 5'd4,  S_WAIT  = 5'd5,  S_CALC0 = 5'd6,  S_CALC1 = 5'd7,
                         S_CALC2 = 5'd8,  S_CALC3 = 5'd9,  S_WR0   = 5'd10, S_WR1   = 5'd11,
                         S_WR2   = 5'd12, S_WR3   = 5'd13, S_WR4   = 5'd14, S_WR5   = 5'd15,
                         S_DONE  = 5'd16;

  logic [4:0]  state_q, state_d;
  logic [14:0] grp_q, grp_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d, done_q, done_d, armed_q, armed_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] y01_q, y23_q, u_q, v_q;
  logic [3:0][7:0] r_q, gn_q, b_q;
  logic [RD_LAT-1:0][2:0] rd_vld_pipe;

  logic [17:0] g18;
  logic [1:0]  pk;
  logic [2:0]  wi, tag_out;
  logic [7:0]  yk, uk, vk;
  logic [23:0] rgb_k;
  logic [5:0][15:0] words;
  logic        is_rd, is_calc;

  function automatic logic [7:0] clip8(input logic signed [31:0] x);
    if (x < 0)                return 8'd0;
    else if (x >= 32'sd16777216) return 8'd255;
    else                      return x[23:16];
  endfunction

  function automatic logic [23:0] csc(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    logic signed [31:0] ys, us, vs;
    ys = $signed({24'd0, y}) - 32'sd16;
    us = $signed({24'd0, u}) - 32'sd128;
    vs = $signed({24'd0, v}) - 32'sd128;
    return {clip8(32'sd76284 * ys + 32'sd104595 * vs),
            clip8(32'sd76284 * ys - 32'sd25624 * us - 32'sd53281 * vs),
            clip8(32'sd76284 * ys + 32'sd132251 * us)};
  endfunction

  assign g18     = {3'd0, grp_q};
  assign is_rd   = (state_q >= S_RD0) && (state_q <= S_RD3);
  assign is_calc = (state_q >= S_CALC0) && (state_q <= S_CALC3);
  assign pk      = 2'(state_q - S_CALC0);
  assign wi      = 3'(state_q - S_WR0);
  assign tag_out = rd_vld_pipe[RD_LAT-1];

  // Pixels 0,1 share the high chroma byte, pixels 2,3 the low one.
  always_comb begin
    case (pk)
      2'd0:    yk = y01_q[15:8];
      2'd1:    yk = y01_q[7:0];
      2'd2:    yk = y23_q[15:8];
      default: yk = y23_q[7:0];
    endcase
    uk = pk[1] ? u_q[7:0] : u_q[15:8];
    vk = pk[1] ? v_q[7:0] : v_q[15:8];
  end
  assign rgb_k = csc(yk, uk, vk);

  assign words[0] = {r_q[0],  gn_q[0]};
  assign words[1] = {b_q[0],  r_q[1]};
  assign words[2] = {gn_q[1], b_q[1]};
  assign words[3] = {r_q[2],  gn_q[2]};
  assign words[4] = {b_q[2],  r_q[3]};
  assign words[5] = {gn_q[3], b_q[3]};

  // Outputs are registered, so each state loads the values the next state presents.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    done_d  = 1'b0;
    wcnt_d  = wcnt_q;
    armed_d = armed_q | ~Enable;
    if (!Enable) begin
      state_d = S_IDLE;
      grp_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (armed_q) begin
          state_d = S_RD0;
          grp_d   = '0;
          addr_d  = Y_BASE;
          armed_d = 1'b0;
        end
        S_RD0: begin state_d = S_RD1; addr_d = Y_BASE + {g18[16:0], 1'b0} + 18'd1; end
        S_RD1: begin state_d = S_RD2; addr_d = U_BASE + g18; end
        S_RD2: begin state_d = S_RD3; addr_d = V_BASE + g18; end
        S_RD3: begin state_d = S_WAIT; wcnt_d = '0; end
        S_WAIT: begin
          if (wcnt_q == 4'(RD_LAT - 1)) state_d = S_CALC0;
          else                          wcnt_d  = wcnt_q + 4'd1;
        end
        S_CALC0, S_CALC1, S_CALC2: state_d = state_q + 5'd1;
        S_CALC3: begin
          state_d = S_WR0;
          we_n_d  = 1'b0;
          addr_d  = RGB_BASE + g18 * 18'd6;
          wdata_d = words[0];
        end
        S_WR0, S_WR1, S_WR2, S_WR3, S_WR4: begin
          state_d = state_q + 5'd1;
          we_n_d  = 1'b0;
          addr_d  = addr_q + 18'd1;
          wdata_d = words[wi + 3'd1];
        end
        S_WR5: begin
          if (grp_q == NUM_GROUPS - 15'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD0;
            grp_d   = grp_q + 15'd1;
            addr_d  = Y_BASE + {g18[16:0] + 17'd1, 1'b0};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      grp_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_n_q      <= 1'b1;
      done_q      <= 1'b0;
      armed_q     <= 1'b1;
      wcnt_q      <= '0;
      y01_q       <= '0;
      y23_q       <= '0;
      u_q         <= '0;
      v_q         <= '0;
      r_q         <= '0;
      gn_q        <= '0;
      b_q         <= '0;
      rd_vld_pipe <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      done_q  <= done_d;
      armed_q <= armed_d;
      wcnt_q  <= wcnt_d;
      // Tag each read with its word index; it surfaces when the data arrives.
      for (int i = RD_LAT - 1; i > 0; i--) rd_vld_pipe[i] <= rd_vld_pipe[i-1];
      rd_vld_pipe[0] <= {is_rd, 2'(state_q - S_RD0)};
      if (tag_out[2]) begin
        case (tag_out[1:0])
          2'd0:    y01_q <= SRAM_read_data;
          2'd1:    y23_q <= SRAM_read_data;
          2'd2:    u_q   <= SRAM_read_data;
          default: v_q   <= SRAM_read_data;
        endcase
      end
      if (is_calc) begin
        r_q[pk]  <= rgb_k[23:16];
        gn_q[pk] <= rgb_k[15:8];
        b_q[pk]  <= rgb_k[7:0];
      end
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Done            = done_q;
endmodule

// File: tb/tb_yuv_to_rgb_converter.sv
// Directed bench: short frames (3 groups ending at address 262143) against an SRAM model.
module tb_yuv_to_rgb_converter;
  localparam int          NG  = 3;
  localparam logic [17:0] RGB = 18'd262126;
  localparam logic [17:0] UB  = 18'd38400;
  localparam logic [17:0] VB  = 18'd57600;

  logic        Clock = 1'b0, Resetn = 1'b0, Enable = 1'b0;
  logic [15:0] rd_data, wr_data;
  logic [17:0] addr;
  logic        we_n, done;

  yuv_to_rgb_converter #(.RGB_BASE(RGB), .NUM_GROUPS(15'(NG))) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
    .SRAM_address(addr), .SRAM_read_data(rd_data),
    .SRAM_write_data(wr_data), .SRAM_we_n(we_n), .Done(done));

  always #5 Clock = ~Clock;

  logic [15:0] mem [0:262143];
  logic [15:0] p1;
  logic [17:0] wa_q [$];
  logic [15:0] wd_q [$];
  logic [15:0] expw [0:NG*6-1];
  int total = 0, bad = 0;

  // Two-clock read latency SRAM; writes are logged rather than stored.
  always @(posedge Clock) begin
    p1      <= mem[addr];
    rd_data <= p1;
    if (!we_n) begin
      wa_q.push_back(addr);
      wd_q.push_back(wr_data);
    end
  end

  typedef struct {
    string       nm;
    logic [15:0] y, u, v;
    logic [15:0] w [6];
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] clipm(input int x);
    int s;
    s = x >>> 16;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic logic [23:0] pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    int yy, uu, vv;
    yy = int'(y) - 16; uu = int'(u) - 128; vv = int'(v) - 128;
    return {clipm(76284*yy + 104595*vv), clipm(76284*yy - 25624*uu - 53281*vv), clipm(76284*yy + 132251*uu)};
  endfunction

  task automatic fill(input int g, input logic [15:0] y01, input logic [15:0] y23,
                      input logic [15:0] u, input logic [15:0] v);
    mem[2*g] = y01; mem[2*g+1] = y23; mem[int'(UB)+g] = u; mem[int'(VB)+g] = v;
  endtask

  task automatic run_frame(input string nm);
    int cyc, ndone, first;
    logic [17:0] daddr;
    wa_q.delete(); wd_q.delete();
    ndone = 0; first = 0; daddr = '0; cyc = 0;
    @(negedge Clock); Enable = 1'b1;
    repeat (NG*16 + 20) begin
      @(posedge Clock); #1; cyc++;
      if (done) begin
        ndone++;
        if (first == 0) begin first = cyc; daddr = addr; end
      end
    end
    @(negedge Clock); Enable = 1'b0;
    @(negedge Clock);
    chk({nm, "_nwr"}, wa_q.size(), NG*6);
    for (int i = 0; i < wa_q.size() && i < NG*6; i++) begin
      chk({nm, "_addr"}, wa_q[i], RGB + 18'(i));
      chk({nm, "_data"}, wd_q[i], expw[i]);
    end
    chk({nm, "_ndone"}, ndone, 1);
    chk({nm, "_done_cyc"}, first, NG*16 + 1);
    chk({nm, "_done_addr"}, daddr, 18'd262143);
  endtask

  task automatic setv(input int i, input string nm, input logic [15:0] y, input logic [15:0] u,
                      input logic [15:0] v, input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4,
                      input logic [15:0] w5);
    vt[i].nm = nm; vt[i].y = y; vt[i].u = u; vt[i].v = v;
    vt[i].w[0] = w0; vt[i].w[1] = w1; vt[i].w[2] = w2;
    vt[i].w[3] = w3; vt[i].w[4] = w4; vt[i].w[5] = w5;
  endtask

  initial begin
    int nw;
    logic seen_done;
    logic [23:0] p [4];
    logic [15:0] y01, y23, u, v;

    setv(0, "black",  16'h1010, 16'h8080, 16'h8080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    setv(1, "white",  16'hFFFF, 16'h8080, 16'h8080, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    setv(2, "negclp", 16'h0000, 16'h8080, 16'h8080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    setv(3, "bclip",  16'hFFFF, 16'hFFFF, 16'h8080, 16'hFFE4, 16'hFFFF, 16'hE4FF, 16'hFFE4, 16'hFFFF, 16'hE4FF);
    setv(4, "chroma", 16'h8080, 16'h80FF, 16'h8080, 16'h8282, 16'h8282, 16'h8282, 16'h8250, 16'hFF82, 16'h50FF);
    setv(5, "vclip",  16'h8080, 16'h8080, 16'hFFFF, 16'hFF1B, 16'h82FF, 16'h1B82, 16'hFF1B, 16'h82FF, 16'h1B82);

    #12;
    chk("rst_addr", addr, 18'd0);
    chk("rst_wdata", wr_data, 16'd0);
    chk("rst_we_n", we_n, 1'b1);
    chk("rst_done", done, 1'b0);
    @(negedge Clock); Resetn = 1'b1;

    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < NG; g++) fill(g, vt[k].y, vt[k].y, vt[k].u, vt[k].v);
      for (int i = 0; i < NG*6; i++) expw[i] = vt[k].w[i % 6];
      run_frame(vt[k].nm);
    end

    // Varied data per group, checked against the bench model.
    for (int g = 0; g < NG; g++) begin
      y01 = 16'($urandom); y23 = 16'($urandom); u = 16'($urandom); v = 16'($urandom);
      fill(g, y01, y23, u, v);
      p[0] = pix(y01[15:8], u[15:8], v[15:8]);
      p[1] = pix(y01[7:0],  u[15:8], v[15:8]);
      p[2] = pix(y23[15:8], u[7:0],  v[7:0]);
      p[3] = pix(y23[7:0],  u[7:0],  v[7:0]);
      expw[g*6+0] = p[0][23:8];
      expw[g*6+1] = {p[0][7:0], p[1][23:16]};
      expw[g*6+2] = p[1][15:0];
      expw[g*6+3] = p[2][23:8];
      expw[g*6+4] = {p[2][7:0], p[3][23:16]};
      expw[g*6+5] = p[3][15:0];
    end
    run_frame("rand");

    // Abort during group 1 WR2.
    for (int g = 0; g < NG; g++) fill(g, 16'h8080, 16'h8080, 16'h80FF, 16'h8080);
    wa_q.delete(); wd_q.delete();
    @(negedge Clock); Enable = 1'b1;
    nw = 0;
    for (int c = 0; c < 100 && nw < 9; c++) begin
      @(negedge Clock);
      if (!we_n) nw++;
    end
    chk("abort_reach_wr2", nw, 9);
    Enable = 1'b0;
    @(posedge Clock); #1;
    chk("abort_we_n", we_n, 1'b1);
    seen_done = done;
    repeat (10) begin @(posedge Clock); #1; seen_done |= done; end
    chk("abort_no_done", seen_done, 1'b0);
    chk("abort_nwr", wa_q.size(), 9);

    // Restart from group 0, then reset in the middle of the reads.
    @(negedge Clock); Enable = 1'b1;
    @(posedge Clock); #1; chk("restart_y0", addr, 18'd0);
    @(posedge Clock); #1; chk("restart_y1", addr, 18'd1);
    @(posedge Clock); #1; chk("restart_u", addr, UB);
    #2; Resetn = 1'b0; #1;
    chk("mid_rst_addr", addr, 18'd0);
    chk("mid_rst_wdata", wr_data, 16'd0);
    chk("mid_rst_we_n", we_n, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    Enable = 1'b0;
    @(negedge Clock); Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    chk("post_rst_idle_addr", addr, 18'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
